// File: rtl/tone_wave_gen.sv
// tone_wave_gen: turns a tone frequency into a square wave (half-period from a restoring divider)
// and serialises it as signed 16-bit stereo samples to the board DAC.
module tone_wave_gen #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned SILENT_HZ = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] tone,
    input  logic [15:0] volume,
    output logic        busy,
    output logic        wave,
    output logic        audio_mclk,
    output logic        audio_sck,
    output logic        audio_lrck,
    output logic        audio_sdin
);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      r_state, w_state_nx;
    logic [31:0] r_tone_q, r_half_period, r_quo, r_phase, r_shreg;
    logic [32:0] r_dvsr, r_rem;
    logic [4:0]  r_step;
    logic [8:0]  r_cnt;
    logic        r_silent, r_wave;
    logic        w_change, w_tone_silent, w_fits, w_play;
    logic [33:0] w_trial, w_diff;
    logic [15:0] w_mag, w_sample;

    assign w_change      = tone != r_tone_q;
    assign w_tone_silent = (tone == 32'd0) || (tone >= 32'(SILENT_HZ));
    // Dividend bits are consumed from r_quo's MSB while quotient bits enter at its LSB.
    assign w_trial       = {r_rem, r_quo[31]};
    assign w_diff        = w_trial - {1'b0, r_dvsr};
    assign w_fits        = ~w_diff[33];
    assign w_play        = en && !r_silent && (r_half_period != 32'd0);
    assign w_mag         = volume & 16'h7FFF;
    assign w_sample      = (!en || r_silent) ? 16'h0000 : (r_wave ? w_mag : -w_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (r_state == IDLE && w_change && !w_tone_silent) w_state_nx = DIV;
        else if (r_state == DIV && r_step == 5'd31)        w_state_nx = DONE;
        else if (r_state == DONE)                          w_state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tone_q <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_step   <= '0;
        end else if (r_state == IDLE) begin
            if (w_change) begin
                r_tone_q <= tone;
                r_rem    <= '0;
                r_quo    <= 32'(CLK_HZ);
                r_dvsr   <= {tone, 1'b0};
                r_step   <= '0;
            end
        end else if (r_state == DIV) begin
            r_rem  <= w_fits ? w_diff[32:0] : w_trial[32:0];
            r_quo  <= {r_quo[30:0], w_fits};
            r_step <= r_step + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_silent      <= 1'b1;
            r_half_period <= '0;
            r_phase       <= '0;
            r_wave        <= 1'b0;
        end else begin
            if (r_state == IDLE && w_change && w_tone_silent) r_silent <= 1'b1;
            if (r_state == DONE) begin
                r_half_period <= r_quo;
                r_silent      <= 1'b0;
                r_phase       <= '0;
            end else if (w_play) begin
                if (r_phase == r_half_period - 32'd1) begin
                    r_phase <= '0;
                    r_wave  <= ~r_wave;
                end else begin
                    r_phase <= r_phase + 32'd1;
                end
            end else begin
                r_phase <= '0;
                r_wave  <= 1'b0;
            end
        end
    end

    // Load on the frame wrap beats the shift that would also fall on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shreg <= '0;
        end else begin
            r_cnt <= r_cnt + 9'd1;
            if (r_cnt == 9'd511)         r_shreg <= {w_sample, w_sample};
            else if (r_cnt[3:0] == 4'hF) r_shreg <= {r_shreg[30:0], 1'b0};
        end
    end

    assign busy       = r_state != IDLE;
    assign wave       = r_wave;
    assign audio_mclk = r_cnt[1];
    assign audio_sck  = r_cnt[3];
    assign audio_lrck = r_cnt[8];
    assign audio_sdin = r_shreg[31];
endmodule

// File: tb/tb_tone_wave_gen.sv
// tb_tone_wave_gen: directed checks of divider, wave and DAC serialiser for tone_wave_gen.
module tb_tone_wave_gen;
    logic        clk, rst_n, en;
    logic [31:0] tone;
    logic [15:0] volume;
    logic        busy, wave, audio_mclk, audio_sck, audio_lrck, audio_sdin;
    int          checks, failures;

    tone_wave_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tone(tone), .volume(volume),
        .busy(busy), .wave(wave), .audio_mclk(audio_mclk), .audio_sck(audio_sck),
        .audio_lrck(audio_lrck), .audio_sdin(audio_sdin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        while (wave !== lvl && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for the next frame start (lrck falling) and collects the 32 bits seen on sck rising.
    task automatic get_frame(output logic [31:0] f, output int k);
        logic pl, ps;
        f  = '0;
        k  = 0;
        pl = audio_lrck;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (pl && !audio_lrck) break;
            pl = audio_lrck;
        end
        ps = audio_sck;
        for (int c = 0; c < 520 && k < 32; c++) begin
            @(negedge clk);
            if (!ps && audio_sck) begin
                f = {f[30:0], audio_sdin};
                k++;
            end
            ps = audio_sck;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] exp_hp);
        int nb, lat;
        nb  = 0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (busy) nb++;
            if (lat == 0 && dut.r_half_period == exp_hp) lat = n;
        end
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        chk({tag, "_latency"}, 64'(lat), 64'd34);
        chk({tag, "_half_period"}, 64'(dut.r_half_period), 64'(exp_hp));
    endtask

    initial begin
        int          nm, ns, nl, nbusy, nsd, n1, n2, k, rises;
        logic        pm, ps, pl, pb, seen;
        logic [31:0] f;
        checks = 0; failures = 0;
        rst_n = 1'b1; en = 1'b0; tone = '0; volume = 16'h9000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", 64'({busy, wave, audio_mclk, audio_sck, audio_lrck, audio_sdin}), 64'd0);
        chk("reset_silent", 64'(dut.r_silent), 64'd1);
        repeat (3) @(negedge clk);
        en = 1'b1;
        rst_n = 1'b1;

        // tone 0: no division, silent stream, DAC clocks free-running
        nm = 0; ns = 0; nl = 0; nbusy = 0; nsd = 0;
        pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
        for (int n = 0; n < 1024; n++) begin
            @(negedge clk);
            if (audio_mclk != pm) nm++;
            if (audio_sck != ps) ns++;
            if (audio_lrck != pl) nl++;
            if (busy) nbusy++;
            if (audio_sdin) nsd++;
            pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
        end
        chk("idle_mclk_toggles", 64'(nm), 64'd512);
        chk("idle_sck_toggles", 64'(ns), 64'd128);
        chk("idle_lrck_toggles", 64'(nl), 64'd4);
        chk("idle_busy_cycles", 64'(nbusy), 64'd0);
        chk("idle_sdin_ones", 64'(nsd), 64'd0);

        // 100e6 / 880 = 113636
        tone = 32'd440;
        run_div("div440", 32'd113636);

        // 100e6/2216 = 45126, then only the latest tone: 100e6/1976 = 50607
        tone = 32'd1108;
        rises = 0; seen = 1'b0; pb = busy;
        for (int n = 1; n <= 130; n++) begin
            @(negedge clk);
            if (n == 5) tone = 32'd988;
            if (busy && !pb) rises++;
            pb = busy;
            if (dut.r_half_period == 32'd45126) seen = 1'b1;
        end
        chk("retone_runs", 64'(rises), 64'd2);
        chk("retone_first_hp", 64'(seen), 64'd1);
        chk("retone_final_hp", 64'(dut.r_half_period), 64'd50607);

        // 100e6/39998 = 2500 -> wave high 2500, period 5000
        tone = 32'd19999;
        repeat (40) @(negedge clk);
        chk("hp19999", 64'(dut.r_half_period), 64'd2500);
        wait_level(1'b0, n1);
        wait_level(1'b1, n1);
        wait_level(1'b0, n1);
        wait_level(1'b1, n2);
        chk("wave_high_len", 64'(n1), 64'd2500);
        chk("wave_period", 64'(n1 + n2), 64'd5000);
        get_frame(f, k);
        chk("frame_pos_bits", 64'(k), 64'd32);
        chk("frame_pos", 64'(f), 64'h10001000);
        wait_level(1'b0, n1);
        get_frame(f, k);
        chk("frame_neg", 64'(f), 64'hF000F000);

        // rests
        tone = 32'd20000;
        @(negedge clk);
        chk("rest20000_silent", 64'(dut.r_silent), 64'd1);
        chk("rest20000_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("rest20000_wave", 64'(wave), 64'd0);
        get_frame(f, k);
        chk("rest20000_frame", 64'(f), 64'd0);
        tone = 32'd40000;
        nbusy = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        chk("rest40000_busy", 64'(nbusy), 64'd0);
        chk("rest40000_silent", 64'(dut.r_silent), 64'd1);

        // en=0 mutes and holds the phase counter
        tone = 32'd19999;
        repeat (40) @(negedge clk);
        wait_level(1'b1, n1);
        chk("en_wave_up", 64'(wave), 64'd1);
        en = 1'b0;
        @(negedge clk);
        chk("en0_wave", 64'(wave), 64'd0);
        get_frame(f, k);
        chk("en0_frame", 64'(f), 64'd0);
        chk("en0_phase", 64'(dut.r_phase), 64'd0);

        // reset during division
        en = 1'b1;
        tone = 32'd440;
        repeat (10) @(negedge clk);
        chk("middiv_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("middiv_reset_outputs", 64'({busy, wave, audio_mclk, audio_sck, audio_lrck, audio_sdin}), 64'd0);
        chk("middiv_reset_hp", 64'(dut.r_half_period), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_div("rediv440", 32'd113636);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
